// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD converter sharing logic.
// Rev 1.0
`default_nettype none

package bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [31:0] BCD_MAX    = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT    = 32'h9999_9999;
  localparam int          BCD_DIGITS = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after i_ptr.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic          w_found;
  logic [IW-1:0] w_pos;
  int            w_j;

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // i_ptr is always below N, so a single subtraction wraps the scan.
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      w_pos = IW'(w_j);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
    o_valid = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_share_arbiter.sv
// bcd_share_arbiter: round-robin shares one binary-to-BCD converter among N_REQ sources,
// with operand range check, converter timeout and a tagged result. Rev 1.0
`default_nettype none

module bcd_share_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_conv_start,
  output logic [DATA_W-1:0]       o_conv_data,
  input  logic                    i_conv_done,
  input  logic [4*BCD_DIGITS-1:0] i_conv_bcd,
  output logic                    o_rsp_valid,
  output logic [2:0]              o_rsp_id,
  output logic [4*BCD_DIGITS-1:0] o_rsp_bcd,
  output logic                    o_rsp_ovf,
  output logic                    o_rsp_err,
  output logic                    o_busy
);

  localparam int              IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int              CW         = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0]   c_last_idx = IW'(N_REQ - 1);
  localparam logic [CW-1:0]   c_tmo_last = CW'(TIMEOUT_CYC - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [IW-1:0]             r_ptr;
  logic [IW-1:0]             r_id;
  logic [N_REQ-1:0]          r_grant;
  logic [DATA_W-1:0]         r_operand;
  logic [DATA_W-1:0]         r_conv_data;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_rsp_id;
  logic [4*BCD_DIGITS-1:0]   r_rsp_bcd;
  logic                      r_rsp_ovf;
  logic                      r_rsp_err;

  logic [N_REQ-1:0]          w_grant;
  logic [IW-1:0]             w_idx;
  logic                      w_any;
  logic                      w_ovf;
  logic                      w_tmo;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_ovf = (r_operand > DATA_W'(BCD_MAX));
  assign w_tmo = (r_cnt == c_tmo_last);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_CHECK;
      ST_CHECK: w_next = w_ovf ? ST_RESP : ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (i_conv_done || w_tmo) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == ST_CHECK) ? r_grant : '0;
    o_conv_start = (r_state == ST_START);
    o_rsp_valid  = (r_state == ST_RESP);
    o_busy       = (r_state != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_grant     <= '0;
      r_operand   <= '0;
      r_conv_data <= '0;
      r_cnt       <= '0;
      r_rsp_id    <= '0;
      r_rsp_bcd   <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_operand <= i_req_data[w_idx*DATA_W +: DATA_W];
          r_id      <= w_idx;
          r_grant   <= w_grant;
          r_ptr     <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
          r_rsp_ovf <= 1'b0;
          r_rsp_err <= 1'b0;
        end
        ST_CHECK: begin
          if (w_ovf) begin
            r_rsp_bcd <= BCD_SAT;
            r_rsp_ovf <= 1'b1;
            r_rsp_id  <= 3'(r_id);
          end else begin
            r_conv_data <= r_operand;
          end
        end
        ST_START: r_cnt <= '0;
        ST_WAIT: begin
          // A done coinciding with the last timeout cycle still delivers the result.
          if (i_conv_done) begin
            r_rsp_bcd <= i_conv_bcd;
            r_rsp_id  <= 3'(r_id);
          end else if (w_tmo) begin
            r_rsp_bcd <= '0;
            r_rsp_err <= 1'b1;
            r_rsp_id  <= 3'(r_id);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_conv_data = r_conv_data;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_bcd   = r_rsp_bcd;
  assign o_rsp_ovf   = r_rsp_ovf;
  assign o_rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
